// File: rtl/encoder_event_gen_pkg.sv
// Shared keyboard event definitions: event-type tags, encoder code base and quadrature step lookup.
// Combinational helpers only; no latency and no backpressure.
package kb_event_pkg;

  localparam int CODE_W   = 8;
  localparam int ENC_BASE = 40;

  localparam logic [1:0] KEY_RELEASE = 2'b10;
  localparam logic [1:0] KEY_PRESS   = 2'b01;
  localparam logic [1:0] ENC_EVENT   = 2'b11;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_CW   = 2'b01,
    STEP_CCW  = 2'b10,
    STEP_BAD  = 2'b11
  } quadStep_e;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arbState_e;

  // Clockwise successor of a {A,B} state: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] cwNext(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic quadStep_e quadStep(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)              return STEP_NONE;
    else if (cur == cwNext(prev)) return STEP_CW;
    else if (prev == cwNext(cur)) return STEP_CCW;
    else                          return STEP_BAD;
  endfunction

endpackage

// File: rtl/encoder_event_gen_if.sv
// Event handshake bundle: evValid/evCode held by the producer until evAck is sampled high.
// Wiring only; no latency and no storage.
interface encoder_event_gen_if;
  import kb_event_pkg::*;

  logic              evValid;
  logic [CODE_W-1:0] evCode;
  logic              evAck;

  modport master (output evValid, output evCode, input evAck);
  modport slave  (input evValid, input evCode, output evAck);

endinterface

// File: rtl/encoder_event_gen_quad_detent_decoder.sv
// One encoder: 2-flop sync, quadrature decode, sub-step and saturating signed pending-detent count.
// Input change to pending update is 2 edges after sampling; dec retires one detent of direction decCcw.
module quad_detent_decoder #(
  parameter int STEPS_PER_DETENT = 4,
  parameter int PEND_WIDTH       = 3
) (
  input  logic keyClkScan,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic dec,
  input  logic decCcw,
  output logic pendNonZero,
  output logic pendSign,
  output logic ovf
);
  import kb_event_pkg::*;

  localparam logic signed [3:0] SUB_LIM = 4'(STEPS_PER_DETENT);
  localparam logic signed [PEND_WIDTH+1:0] PEND_MAX = (PEND_WIDTH+2)'((1 << (PEND_WIDTH-1)) - 1);
  localparam logic signed [PEND_WIDTH+1:0] PEND_MIN = -PEND_MAX;

  logic [1:0]                   syncA, syncB, prevState, curState;
  logic                         initFlag, ovfNext;
  logic signed [3:0]            subCnt, subNext;
  logic signed [PEND_WIDTH-1:0] pendCnt, pendNext;
  logic signed [1:0]            detent, ackAdj;
  logic signed [PEND_WIDTH+1:0] pendSum;
  quadStep_e                    step;

  always_comb begin
    curState = {syncA[1], syncB[1]};
    step     = quadStep(prevState, curState);
    subNext  = subCnt;
    detent   = 2'sd0;
    ackAdj   = 2'sd0;
    ovfNext  = 1'b0;
    if (!initFlag) begin
      if (step == STEP_CW)       subNext = subCnt + 4'sd1;
      else if (step == STEP_CCW) subNext = subCnt - 4'sd1;
    end
    if (subNext == SUB_LIM) begin
      subNext = 4'sd0;
      detent  = 2'sd1;
    end else if (subNext == -SUB_LIM) begin
      subNext = 4'sd0;
      detent  = -2'sd1;
    end
    // The ack retires the presented direction, so the count may cross zero.
    if (dec) ackAdj = decCcw ? 2'sd1 : -2'sd1;
    pendSum = (PEND_WIDTH+2)'(pendCnt) + (PEND_WIDTH+2)'(detent) + (PEND_WIDTH+2)'(ackAdj);
    if (pendSum > PEND_MAX) begin
      pendNext = PEND_MAX[PEND_WIDTH-1:0];
      ovfNext  = (detent != 2'sd0);
    end else if (pendSum < PEND_MIN) begin
      pendNext = PEND_MIN[PEND_WIDTH-1:0];
      ovfNext  = (detent != 2'sd0);
    end else begin
      pendNext = pendSum[PEND_WIDTH-1:0];
    end
  end

  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      syncA     <= 2'b11;
      syncB     <= 2'b11;
      prevState <= 2'b11;
      initFlag  <= 1'b1;
      subCnt    <= '0;
      pendCnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      syncA     <= {syncA[0], a};
      syncB     <= {syncB[0], b};
      prevState <= curState;
      initFlag  <= 1'b0;
      subCnt    <= subNext;
      pendCnt   <= pendNext;
      ovf       <= ovfNext;
    end
  end

  assign pendNonZero = |pendCnt;
  assign pendSign    = pendCnt[PEND_WIDTH-1];

endmodule

// File: rtl/encoder_event_gen.sv
// Four rotary encoders to 8-bit detent events, round-robin arbitrated onto one valid/ack port.
// Pending detent to evValid is 1 edge; event held until evAck, then at least one idle cycle.
module encoder_event_gen #(
  parameter int STEPS_PER_DETENT = 4,
  parameter int PEND_WIDTH       = 3,
  parameter int ENC_BASE         = kb_event_pkg::ENC_BASE
) (
  input  logic                keyClkScan,
  input  logic                rst,
  input  logic [3:0]          encLinesA,
  input  logic [3:0]          encLinesB,
  encoder_event_gen_if.master evBus,
  output logic [3:0]          pendOvf
);
  import kb_event_pkg::*;

  arbState_e         state, stateNext;
  logic [1:0]        ptr, ptrNext, srvIdx, srvIdxNext, pickIdx, idx;
  logic              srvCcw, srvCcwNext, pickFound;
  logic [CODE_W-1:0] codeReg, codeNext;
  logic [3:0]        pendNZ, pendNeg, dec;

  for (genvar n = 0; n < 4; n++) begin : gDec
    quad_detent_decoder #(
      .STEPS_PER_DETENT(STEPS_PER_DETENT),
      .PEND_WIDTH      (PEND_WIDTH)
    ) uDec (
      .keyClkScan (keyClkScan),
      .rst        (rst),
      .a          (encLinesA[n]),
      .b          (encLinesB[n]),
      .dec        (dec[n]),
      .decCcw     (srvCcw),
      .pendNonZero(pendNZ[n]),
      .pendSign   (pendNeg[n]),
      .ovf        (pendOvf[n])
    );
  end

  // Walk offsets high to low so the encoder nearest the pointer wins.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = ptr;
    idx       = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (pendNZ[idx]) begin
        pickFound = 1'b1;
        pickIdx   = idx;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    ptrNext    = ptr;
    srvIdxNext = srvIdx;
    srvCcwNext = srvCcw;
    codeNext   = codeReg;
    dec        = '0;
    case (state)
      ARB_IDLE: begin
        if (pickFound) begin
          stateNext  = ARB_PRESENT;
          srvIdxNext = pickIdx;
          srvCcwNext = pendNeg[pickIdx];
          codeNext   = {ENC_EVENT, 6'(ENC_BASE + 2 * int'(pickIdx) + int'(pendNeg[pickIdx]))};
        end
      end
      ARB_PRESENT: begin
        if (evBus.evAck) begin
          stateNext   = ARB_IDLE;
          ptrNext     = srvIdx + 2'd1;
          dec[srvIdx] = 1'b1;
        end
      end
      default: stateNext = ARB_IDLE;
    endcase
  end

  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      ptr     <= 2'd0;
      srvIdx  <= 2'd0;
      srvCcw  <= 1'b0;
      codeReg <= '0;
    end else begin
      state   <= stateNext;
      ptr     <= ptrNext;
      srvIdx  <= srvIdxNext;
      srvCcw  <= srvCcwNext;
      codeReg <= codeNext;
    end
  end

  assign evBus.evValid = (state == ARB_PRESENT);
  assign evBus.evCode  = codeReg;

endmodule
